// File: rtl/serial_add_driver.sv
// serial_add_driver: shifts two operands LSB-first to a bit-serial adder and reassembles the sum
module serial_add_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             x,
  output logic             y,
  input  logic             z,
  output logic [WIDTH:0]   sum,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, FLUSH = 2'd2, DONE = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum_q, sum_d;
  // Operand registers drain to zero after WIDTH shifts, so x/y are plain flop outputs that read 0 outside SHIFT
  assign x         = a_q[0];
  assign y         = b_q[0];
  assign sum       = sum_q;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {z, sum_q[WIDTH:1]};
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == CW'(WIDTH - 1) ? FLUSH : SHIFT;
      end
      FLUSH: begin
        sum_d   = {z, sum_q[WIDTH:1]};
        state_d = DONE;
      end
      default: state_d = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
    end
  end
endmodule

// File: tb/tb_serial_add_driver.sv
// tb_serial_add_driver: random and directed operations against a bit-serial adder and a+b reference
module tb_serial_add_driver;
  localparam int W = 8;
  logic         clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [W-1:0] a = '0, b = '0;
  logic         x, y, z, in_ready, out_valid, c_q;
  logic [W:0]   sum;
  int           total = 0, bad = 0;
  serial_add_driver #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .x(x), .y(y), .z(z), .sum(sum), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  // Serial full adder on the link, sharing the reset
  assign z = x ^ y ^ c_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) c_q <= 1'b0;
    else c_q <= (x & y) | (x & c_q) | (y & c_q);
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int gap, input int hold);
    logic [W-1:0] xs, ys;
    logic [W:0]   prev;
    int           n;
    prev = sum;
    for (int i = 0; i < gap; i++) begin
      in_valid = 0;
      a = W'($urandom);
      b = W'($urandom);
      step();
    end
    if (gap > 0) chk("held_prev_sum", 16'(sum), 16'(prev));
    in_valid = 1;
    a = ta;
    b = tb;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("in_ready", 16'(in_ready), 16'd1);
    step();
    in_valid = 0;
    a = W'($urandom);
    b = W'($urandom);
    for (int i = 0; i < W; i++) begin
      xs[i] = x;
      ys[i] = y;
      step();
    end
    chk("x_stream", 16'(xs), 16'(ta));
    chk("y_stream", 16'(ys), 16'(tb));
    chk("flush_xy_valid", {13'd0, x, y, out_valid}, 16'd0);
    step();
    chk("latency_valid", 16'(out_valid), 16'd1);
    chk("adder_carry_clear", 16'(c_q), 16'd0);
    out_ready = 0;
    for (int i = 0; i < hold; i++) step();
    chk("hold_state", {14'd0, out_valid, in_ready}, 16'b10);
    chk("sum", 16'(sum), 16'({1'b0, ta} + {1'b0, tb}));
    out_ready = 1;
    step();
    out_ready = $urandom_range(0, 1);
    chk("release", {14'd0, out_valid, in_ready}, 16'b01);
  endtask
  initial begin
    #1;
    chk("reset_state", {11'd0, in_ready, x, y, out_valid, 1'b0}, 16'b10000);
    chk("reset_sum", 16'(sum), 16'd0);
    step();
    rst = 0;
    step();
    run_op(8'h5A, 8'h33, 0, 0);
    run_op(8'hFF, 8'h01, 1, 0);
    run_op(8'hFF, 8'hFF, 0, 0);
    run_op(8'h00, 8'h00, 0, 0);
    run_op(8'h12, 8'h34, 2, 20);
    // Reset in the 4th SHIFT cycle of 0xAA+0x55
    in_valid = 1;
    a = 8'hAA;
    b = 8'h55;
    step();
    in_valid = 0;
    for (int i = 0; i < 3; i++) step();
    rst = 1;
    #1;
    chk("mid_reset_outputs", {11'd0, in_ready, x, y, out_valid, c_q}, 16'b10000);
    chk("mid_reset_sum", 16'(sum), 16'd0);
    step();
    rst = 0;
    step();
    run_op(8'h01, 8'h01, 0, 0);
    for (int k = 0; k < 1000; k++)
      run_op(W'($urandom), W'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
